// File: rtl/hw_sw_msg_channel_if.sv
// Software PIO / consumer signal bundle for hw_sw_msg_channel.
// slave = the channel block, master = software driver plus message consumer.
interface hw_sw_msg_channel_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_WORDS = 10
);
  localparam int unsigned LEN_W = $clog2(NUM_WORDS + 1);

  logic [1:0]                  to_hw_sig;
  logic [DATA_W-1:0]           to_hw_data;
  logic [1:0]                  to_sw_sig;
  logic                        msg_valid;
  logic                        msg_ready;
  logic [LEN_W-1:0]            msg_len;
  logic [NUM_WORDS*DATA_W-1:0] msg_data;
  logic [7:0]                  overflow_cnt;

  modport master (
    output to_hw_sig, to_hw_data, msg_ready,
    input  to_sw_sig, msg_valid, msg_len, msg_data, overflow_cnt
  );

  modport slave (
    input  to_hw_sig, to_hw_data, msg_ready,
    output to_sw_sig, msg_valid, msg_len, msg_data, overflow_cnt
  );
endinterface

// File: rtl/hw_sw_msg_channel.sv
// Multi-word software-to-hardware message channel: 4-phase per-word PIO handshake,
// buffered message handed to game logic via valid/ready. Optional macro: HWSW_SYNC_EN.
module hw_sw_msg_channel #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_WORDS = 10
) (
  input  logic               clk,
  input  logic               reset_n,
  hw_sw_msg_channel_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(NUM_WORDS + 1);

  typedef enum logic [2:0] {
    S_WAIT    = 3'd0,
    S_ACK     = 3'd1,
    S_REL     = 3'd2,
    S_DELIVER = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [NUM_WORDS];
  logic [DATA_W-1:0] mem_d [NUM_WORDS];
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              last_q, last_d;
  logic [7:0]        ovf_q, ovf_d;
  logic [1:0]        sig;
  logic [DATA_W-1:0] data;
  logic [1:0]        to_sw_c;
  logic              valid_c;

`ifdef HWSW_SYNC_EN
  // Two-flop synchronizer for a PIO running in another clock domain
  logic [1:0]        sig_s1_q, sig_s2_q;
  logic [DATA_W-1:0] data_s1_q, data_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_s1_q  <= 2'd0;
      sig_s2_q  <= 2'd0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      sig_s1_q  <= bus.to_hw_sig;
      sig_s2_q  <= sig_s1_q;
      data_s1_q <= bus.to_hw_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign sig  = sig_s2_q;
  assign data = data_s2_q;
`else
  assign sig  = bus.to_hw_sig;
  assign data = bus.to_hw_data;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_WAIT;
    else          state_q <= state_d;
  end

  // Message buffer and bookkeeping registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
      idx_q  <= '0;
      len_q  <= '0;
      last_q <= 1'b0;
      ovf_q  <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= mem_d[i];
      idx_q  <= idx_d;
      len_q  <= len_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next-state and buffer update
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < NUM_WORDS; i++) mem_d[i] = mem_q[i];
    idx_d  = idx_q;
    len_d  = len_q;
    last_d = last_q;
    ovf_d  = ovf_q;

    case (state_q)
      S_WAIT: begin
        if (sig[1]) begin
          if (idx_q == LEN_W'(NUM_WORDS)) begin
            state_d = S_ERROR;
            if (ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
          end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              if (idx_q == LEN_W'(i)) mem_d[i] = data;
            end
            last_d  = (sig == 2'd2);
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        if (sig == 2'd1) begin
          idx_d   = idx_q + LEN_W'(1);
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (sig == 2'd0) begin
          if (last_q) begin
            len_d   = idx_q;
            state_d = S_DELIVER;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_DELIVER: begin
        // Software input is ignored until the consumer takes the message
        if (bus.msg_ready) begin
          for (int i = 0; i < NUM_WORDS; i++) mem_d[i] = '0;
          idx_d   = '0;
          len_d   = '0;
          last_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_ERROR: begin
        if (sig == 2'd0) begin
          for (int i = 0; i < NUM_WORDS; i++) mem_d[i] = '0;
          idx_d   = '0;
          last_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Status outputs are a pure decode of the state register
  always_comb begin
    to_sw_c = 2'd0;
    valid_c = 1'b0;
    case (state_q)
      S_ACK:     to_sw_c = 2'd3;
      S_DELIVER: begin
        to_sw_c = 2'd1;
        valid_c = 1'b1;
      end
      S_ERROR:   to_sw_c = 2'd2;
      default:   to_sw_c = 2'd0;
    endcase
  end

  assign bus.to_sw_sig    = to_sw_c;
  assign bus.msg_valid    = valid_c;
  assign bus.msg_len      = len_q;
  assign bus.overflow_cnt = ovf_q;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign bus.msg_data[g*DATA_W +: DATA_W] = mem_q[g];
  end
endmodule

// File: tb/tb_hw_sw_msg_channel.sv
// Directed bench for hw_sw_msg_channel: reset, message assembly, delivery hold,
// overflow and length boundaries, with ACK latency adapted to HWSW_SYNC_EN.
module tb_hw_sw_msg_channel;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_WORDS = 10;
`ifdef HWSW_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  int   valid_cnt = 0;
  int   lat;
  int   vbefore;
  logic [NUM_WORDS*DATA_W-1:0] held;

  hw_sw_msg_channel_if #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) bus ();

  hw_sw_msg_channel #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.msg_valid) valid_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bounded wait for a status code; returns the number of clocks taken
  task automatic wait_sw(input logic [1:0] want, input string tag, output int cyc);
    cyc = 0;
    while (bus.to_sw_sig !== want && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(tag, 128'(bus.to_sw_sig), 128'(want));
  endtask

  task automatic send_word(input logic [1:0] sig, input logic [7:0] d, input string tag);
    int c;
    bus.to_hw_sig  = sig;
    bus.to_hw_data = d;
    wait_sw(2'd3, {tag, "_ack"}, c);
    chk({tag, "_lat"}, 128'(c), 128'(ACK_LAT));
    bus.to_hw_sig = 2'd1;
    wait_sw(2'd0, {tag, "_rel"}, c);
    bus.to_hw_sig = 2'd0;
    step(3);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.to_hw_sig  = 2'd0;
    bus.to_hw_data = 8'h00;
    bus.msg_ready  = 1'b0;
    step(3);
    chk("rst_sw",    128'(bus.to_sw_sig),    128'd0);
    chk("rst_valid", 128'(bus.msg_valid),    128'd0);
    chk("rst_len",   128'(bus.msg_len),      128'd0);
    chk("rst_data",  128'(bus.msg_data),     128'd0);
    chk("rst_ovf",   128'(bus.overflow_cnt), 128'd0);
    reset_n = 1'b1;
    step(2);

    // Reset in the middle of an ACK
    bus.to_hw_sig  = 2'd3;
    bus.to_hw_data = 8'h77;
    wait_sw(2'd3, "mid_ack", lat);
    reset_n = 1'b0;
    #2;
    chk("midrst_sw",    128'(bus.to_sw_sig), 128'd0);
    chk("midrst_valid", 128'(bus.msg_valid), 128'd0);
    chk("midrst_data",  128'(bus.msg_data),  128'd0);
    bus.to_hw_sig = 2'd0;
    step(2);
    reset_n = 1'b1;
    step(2);

    // Three-word message; first word must land in word 0 after the reset
    send_word(2'd3, 8'h11, "w1");
    send_word(2'd3, 8'h22, "w2");
    send_word(2'd2, 8'h33, "w3");
    chk("m3_valid", 128'(bus.msg_valid), 128'd1);
    chk("m3_len",   128'(bus.msg_len),   128'd3);
    chk("m3_data",  128'(bus.msg_data),  128'h332211);
    chk("m3_sw",    128'(bus.to_sw_sig), 128'd1);

    // Consumer stalls while software misbehaves
    held           = bus.msg_data;
    bus.to_hw_sig  = 2'd3;
    bus.to_hw_data = 8'hAA;
    step(20);
    chk("hold_data",  128'(bus.msg_data),  128'h332211);
    chk("hold_sw",    128'(bus.to_sw_sig), 128'd1);
    chk("hold_valid", 128'(bus.msg_valid), 128'd1);
    chk("hold_len",   128'(bus.msg_len),   128'd3);
    bus.to_hw_sig = 2'd0;
    step(3);
    bus.msg_ready = 1'b1;
    step(1);
    bus.msg_ready = 1'b0;
    chk("acc_valid", 128'(bus.msg_valid), 128'd0);
    chk("acc_data",  128'(bus.msg_data),  128'd0);
    chk("acc_sw",    128'(bus.to_sw_sig), 128'd0);
    step(3);
    chk("acc_idle", 128'(bus.to_sw_sig), 128'd0);

    // Overflow: eleven WORD commands with no WORD_LAST
    vbefore = valid_cnt;
    for (int i = 0; i < 10; i++) send_word(2'd3, 8'(8'h40 + i), "ofw");
    bus.to_hw_sig  = 2'd3;
    bus.to_hw_data = 8'hEE;
    wait_sw(2'd2, "ovf_err", lat);
    chk("ovf_cnt", 128'(bus.overflow_cnt), 128'd1);
    bus.to_hw_sig = 2'd0;
    step(4);
    chk("ovf_sw",      128'(bus.to_sw_sig), 128'd0);
    chk("ovf_data",    128'(bus.msg_data),  128'd0);
    chk("ovf_novalid", 128'(valid_cnt - vbefore), 128'd0);

    // Single-word message
    send_word(2'd2, 8'h5C, "single");
    chk("s_valid", 128'(bus.msg_valid), 128'd1);
    chk("s_len",   128'(bus.msg_len),   128'd1);
    chk("s_data",  128'(bus.msg_data),  128'h5C);
    bus.msg_ready = 1'b1;
    step(1);
    bus.msg_ready = 1'b0;
    chk("s_acc", 128'(bus.msg_valid), 128'd0);
    step(2);

    // Full-length message ending in WORD_LAST
    for (int i = 0; i < 9; i++) send_word(2'd3, 8'(i + 1), "fw");
    send_word(2'd2, 8'h0A, "flast");
    chk("f_valid", 128'(bus.msg_valid),    128'd1);
    chk("f_sw",    128'(bus.to_sw_sig),    128'd1);
    chk("f_len",   128'(bus.msg_len),      128'd10);
    chk("f_data",  128'(bus.msg_data),     128'h0A090807060504030201);
    chk("f_ovf",   128'(bus.overflow_cnt), 128'd1);
    bus.msg_ready = 1'b1;
    step(1);
    bus.msg_ready = 1'b0;
    chk("f_acc", 128'(bus.msg_valid), 128'd0);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
